// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INST_BYTES   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch address: redirect > jump > sequential/refetch, forced to word alignment.
module fetch_next_pc
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            jal_valid,
    input  logic [XLEN-1:0] jal_target,
    input  logic [XLEN-1:0] base_pc,
    input  logic            seq_inc,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] raw_pc;

    always_comb begin
        raw_pc = base_pc;
        if (redirect_valid) begin
            raw_pc = redirect_pc;
        end else if (jal_valid) begin
            raw_pc = jal_target;
        end else if (seq_inc) begin
            raw_pc = base_pc + XLEN'(INST_BYTES);
        end
        next_pc = raw_pc & ~XLEN'(3);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, single output register,
// jump/redirect handling with drain of a stale in-flight response.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | one cycle after reset release, no request
// ST_REQ   | request outstanding at imem_addr_o
// ST_HOLD  | response dropped because output was blocked; refetch on ready
// ST_DRAIN | waiting to discard a stale response, then fetch drain_pc
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i,
    input  logic            jal_valid_i,
    input  logic [XLEN-1:0] jal_target_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            flush_o
);

    localparam logic [XLEN-1:0] RESET_PC = RESET_ADDR & ~XLEN'(3);

    fetch_state_e    state;
    logic [XLEN-1:0] drain_pc;
    logic [XLEN-1:0] next_pc;
    logic            jal_take;

    assign jal_take = jal_valid_i & inst_valid_o & inst_ready_i;

    // HOLD refetches the dropped address, so only REQ advances sequentially.
    fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
        .redirect_valid (redirect_valid_i),
        .redirect_pc    (redirect_pc_i),
        .jal_valid      (jal_take),
        .jal_target     (jal_target_i),
        .base_pc        (imem_addr_o),
        .seq_inc        (state == ST_REQ),
        .next_pc        (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            imem_req_o   <= 1'b0;
            imem_addr_o  <= '0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            flush_o      <= 1'b0;
            drain_pc     <= '0;
        end else begin
            flush_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state       <= ST_REQ;
                    imem_req_o  <= 1'b1;
                    imem_addr_o <= RESET_PC;
                end
                ST_REQ: begin
                    if (redirect_valid_i || jal_take) begin
                        flush_o      <= redirect_valid_i;
                        inst_valid_o <= 1'b0;
                        if (imem_ack_i) begin
                            imem_addr_o <= next_pc;
                        end else begin
                            state      <= ST_DRAIN;
                            imem_req_o <= 1'b0;
                            drain_pc   <= next_pc;
                        end
                    end else if (imem_ack_i) begin
                        if (!inst_valid_o || inst_ready_i) begin
                            inst_o       <= imem_rdata_i;
                            inst_pc_o    <= imem_addr_o;
                            inst_valid_o <= 1'b1;
                            imem_addr_o  <= next_pc;
                        end else begin
                            state      <= ST_HOLD;
                            imem_req_o <= 1'b0;
                        end
                    end else if (inst_ready_i) begin
                        inst_valid_o <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid_i || inst_ready_i) begin
                        flush_o      <= redirect_valid_i;
                        inst_valid_o <= 1'b0;
                        state        <= ST_REQ;
                        imem_req_o   <= 1'b1;
                        imem_addr_o  <= next_pc;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_valid_i) begin
                        flush_o  <= 1'b1;
                        drain_pc <= next_pc;
                    end
                    if (imem_ack_i) begin
                        state       <= ST_REQ;
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= redirect_valid_i ? next_pc : drain_pc;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    imem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an accepted-instruction scoreboard.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic        jal_valid_i;
    logic [31:0] jal_target_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        flush_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_ctrl #(.XLEN(32), .RESET_ADDR(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_rdata_i     (imem_rdata_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_ready_i     (inst_ready_i),
        .jal_valid_i      (jal_valid_i),
        .jal_target_i     (jal_target_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .flush_o          (flush_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // One clock: score any instruction accepted at this edge, then refresh memory data.
    task automatic cycle();
        logic        acc;
        logic [31:0] pc;
        logic [31:0] w;
        exp_t        e;
        acc = inst_valid_o && inst_ready_i;
        pc  = inst_pc_o;
        w   = inst_o;
        @(posedge clk);
        #1;
        if (acc) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra_accept", pc, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_pc", pc, e.pc);
                check_eq("sb_inst", w, e.inst);
            end
        end
        imem_rdata_i = mem_word(imem_addr_o);
    endtask

    task automatic do_reset();
        inst_ready_i     = 1'b0;
        imem_ack_i       = 1'b0;
        jal_valid_i      = 1'b0;
        redirect_valid_i = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        exp_q.delete();
        rst = 1'b0;
        cycle();
        inst_ready_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        imem_ack_i       = 1'b0;
        imem_rdata_i     = '0;
        inst_ready_i     = 1'b0;
        jal_valid_i      = 1'b0;
        jal_target_i     = '0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        cycle();
        cycle();
        check_eq("rst_req", 32'(imem_req_o), 32'd0);
        check_eq("rst_valid", 32'(inst_valid_o), 32'd0);
        check_eq("rst_flush", 32'(flush_o), 32'd0);
        check_eq("rst_inst", inst_o, 32'd0);
        check_eq("rst_pc", inst_pc_o, 32'd0);

        // Streaming fetch at full rate
        do_reset();
        check_eq("first_req", 32'(imem_req_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_addr", imem_addr_o, 32'(i * 4));
            check_eq("seq_req", 32'(imem_req_o), 32'd1);
            push_exp(32'(i * 4));
            imem_ack_i = 1'b1;
            cycle();
            check_eq("seq_pc", inst_pc_o, 32'(i * 4));
            check_eq("seq_flush", 32'(flush_o), 32'd0);
        end
        imem_ack_i = 1'b0;
        cycle();

        // Back-pressure at 'h8: response for 'hC dropped, refetched after HOLD
        do_reset();
        imem_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp(32'(i * 4));
            cycle();
        end
        inst_ready_i = 1'b0;
        cycle();
        imem_ack_i = 1'b0;
        check_eq("hold_req", 32'(imem_req_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_eq("hold_req", 32'(imem_req_o), 32'd0);
            check_eq("hold_valid", 32'(inst_valid_o), 32'd1);
            check_eq("hold_pc", inst_pc_o, 32'h8);
            check_eq("hold_inst", inst_o, mem_word(32'h8));
        end
        inst_ready_i = 1'b1;
        cycle();
        check_eq("hold_next_req", 32'(imem_req_o), 32'd1);
        check_eq("hold_next_addr", imem_addr_o, 32'hC);
        push_exp(32'hC);
        imem_ack_i = 1'b1;
        cycle();
        imem_ack_i = 1'b0;
        cycle();

        // Jump at 'h4 to 'h40 drops the sequential 'h8 response
        do_reset();
        imem_ack_i = 1'b1;
        push_exp(32'h0);
        cycle();
        push_exp(32'h4);
        cycle();
        check_eq("jal_pc_before", inst_pc_o, 32'h4);
        jal_valid_i  = 1'b1;
        jal_target_i = 32'h40;
        cycle();
        jal_valid_i = 1'b0;
        check_eq("jal_valid_drop", 32'(inst_valid_o), 32'd0);
        check_eq("jal_addr", imem_addr_o, 32'h40);
        push_exp(32'h40);
        cycle();
        check_eq("jal_new_pc", inst_pc_o, 32'h40);
        imem_ack_i = 1'b0;
        cycle();

        // Redirect to 'h100 with 'h10 outstanding, ack two cycles later
        do_reset();
        imem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_exp(32'(i * 4));
            cycle();
        end
        check_eq("rd_pending_addr", imem_addr_o, 32'h10);
        imem_ack_i       = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h100;
        cycle();
        redirect_valid_i = 1'b0;
        check_eq("rd_flush", 32'(flush_o), 32'd1);
        check_eq("rd_drain_req", 32'(imem_req_o), 32'd0);
        check_eq("rd_valid", 32'(inst_valid_o), 32'd0);
        cycle();
        check_eq("rd_flush_pulse", 32'(flush_o), 32'd0);
        check_eq("rd_still_drain", 32'(imem_req_o), 32'd0);
        imem_ack_i = 1'b1;
        cycle();
        imem_ack_i = 1'b0;
        check_eq("rd_discard", 32'(inst_valid_o), 32'd0);
        check_eq("rd_new_req", 32'(imem_req_o), 32'd1);
        check_eq("rd_new_addr", imem_addr_o, 32'h100);
        push_exp(32'h100);
        imem_ack_i = 1'b1;
        cycle();
        imem_ack_i = 1'b0;
        cycle();

        // Second redirect during DRAIN overwrites the target
        do_reset();
        push_exp(32'h0);
        imem_ack_i = 1'b1;
        cycle();
        imem_ack_i       = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h100;
        cycle();
        redirect_pc_i = 32'h180;
        cycle();
        redirect_valid_i = 1'b0;
        check_eq("rd2_flush", 32'(flush_o), 32'd1);
        imem_ack_i = 1'b1;
        cycle();
        imem_ack_i = 1'b0;
        check_eq("rd2_flush_end", 32'(flush_o), 32'd0);
        check_eq("rd2_addr", imem_addr_o, 32'h180);

        // Redirect beats jump in the same cycle; misaligned target is aligned
        do_reset();
        imem_ack_i = 1'b1;
        push_exp(32'h0);
        cycle();
        push_exp(32'h4);
        cycle();
        jal_valid_i      = 1'b1;
        jal_target_i     = 32'h40;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h200;
        cycle();
        jal_valid_i = 1'b0;
        check_eq("prio_addr", imem_addr_o, 32'h200);
        check_eq("prio_flush", 32'(flush_o), 32'd1);
        check_eq("prio_valid", 32'(inst_valid_o), 32'd0);
        imem_ack_i    = 1'b0;
        redirect_pc_i = 32'h103;
        cycle();
        redirect_valid_i = 1'b0;
        imem_ack_i       = 1'b1;
        cycle();
        check_eq("align_addr", imem_addr_o, 32'h100);
        push_exp(32'h100);
        cycle();
        imem_ack_i = 1'b0;
        cycle();

        // Reset during a request; a late ack right after release is ignored
        do_reset();
        imem_ack_i = 1'b1;
        push_exp(32'h0);
        cycle();
        push_exp(32'h4);
        cycle();
        imem_ack_i = 1'b0;
        rst        = 1'b1;
        cycle();
        check_eq("mr_rst_req", 32'(imem_req_o), 32'd0);
        check_eq("mr_rst_valid", 32'(inst_valid_o), 32'd0);
        check_eq("mr_rst_pc", inst_pc_o, 32'd0);
        rst          = 1'b0;
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem_word(32'h8);
        cycle();
        imem_ack_i = 1'b0;
        check_eq("mr_first_addr", imem_addr_o, 32'h0);
        check_eq("mr_first_req", 32'(imem_req_o), 32'd1);
        check_eq("mr_no_stale", 32'(inst_valid_o), 32'd0);
        cycle();
        check_eq("mr_no_stale2", 32'(inst_valid_o), 32'd0);
        push_exp(32'h0);
        imem_ack_i = 1'b1;
        cycle();
        imem_ack_i = 1'b0;
        check_eq("mr_fetch_pc", inst_pc_o, 32'h0);
        cycle();

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
